dvfs_controller: RTL and testbench

- Downstream consumer of the 100 MHz clock divider's div2/div4/div8 outputs.
- Measures workload activity over fixed windows and picks a performance level.
- Sequences voltage and frequency changes in safe order through a voltage-regulator handshake.
- Drives a glitch-free selected clock, clk_out, registered in the clk_in domain.

---
 rtl/dvfs_controller.sv | 171 +++++++++++++++++
 tb/tb_dvfs_controller.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dvfs_controller.sv
// Activity-driven DVFS sequencer with regulator handshake and clock mux.
// Ports: clk_in/rst, clk_div2/4/8 in, busy/force in, clk_out, levels, volt handshake, flags.
module dvfs_controller #(
    parameter int WINDOW_LOG2  = 8,
    parameter int HI_THRESH    = 192,
    parameter int LO_THRESH    = 64,
    parameter int VACK_TIMEOUT = 1024
) (
    input  logic       clk_in,
    input  logic       rst,
    input  logic       clk_div2,
    input  logic       clk_div4,
    input  logic       clk_div8,
    input  logic       busy,
    input  logic       force_en,
    input  logic [1:0] force_level,
    output logic       clk_out,
    output logic [1:0] perf_level,
    output logic [1:0] volt_level,
    output logic [1:0] volt_req,
    output logic       volt_req_valid,
    input  logic       volt_ack,
    output logic       switching,
    output logic       err_timeout
);

    localparam int CW = WINDOW_LOG2 + 1;
    localparam int TW = $clog2(VACK_TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(VACK_TIMEOUT - 1);
    localparam logic [CW-1:0] HI_T = CW'(HI_THRESH);
    localparam logic [CW-1:0] LO_T = CW'(LO_THRESH);

    typedef enum logic [1:0] {IDLE, V_UP, F_SWITCH, V_DOWN} state_t;

    state_t                 state_q, state_d;
    logic [WINDOW_LOG2-1:0] win_q, win_d;
    logic [CW-1:0]          busy_q, busy_d;
    logic [1:0]             tgt_q, tgt_d;
    logic [1:0]             perf_q, perf_d;
    logic [1:0]             volt_q, volt_d;
    logic [1:0]             req_q, req_d;
    logic                   vld_q, vld_d;
    logic [TW-1:0]          tmo_q, tmo_d;
    logic                   err_q, err_d;
    logic                   clk_q, clk_d;

    logic          win_end;
    logic [CW-1:0] busy_inc;
    logic [1:0]    force_tgt;
    logic          aligned;
    logic          step_up;
    logic          step_dn;

    assign win_end   = &win_q;
    assign win_d     = win_q + 1'b1;
    // Includes the current cycle so the full window is evaluated.
    assign busy_inc  = (busy && !(&busy_q)) ? busy_q + 1'b1 : busy_q;
    assign busy_d    = win_end ? '0 : busy_inc;
    assign force_tgt = (force_level == 2'd3) ? 2'd2 : force_level;
    // All dividers low: every selectable clock is mid-low, so a switch here cannot cut a high phase.
    assign aligned   = !clk_div2 && !clk_div4 && !clk_div8;

    always_comb begin
        step_up = 1'b0;
        step_dn = 1'b0;
        if (state_q == IDLE) begin
            if (force_en) begin
                step_up = force_tgt > perf_q;
                step_dn = force_tgt < perf_q;
            end else if (win_end) begin
                step_up = (busy_inc >= HI_T) && (perf_q < 2'd2);
                step_dn = !step_up && (busy_inc <= LO_T) && (perf_q != 2'd0);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        tgt_d   = tgt_q;
        perf_d  = perf_q;
        volt_d  = volt_q;
        req_d   = req_q;
        vld_d   = vld_q;
        err_d   = 1'b0;
        tmo_d   = vld_q ? tmo_q + 1'b1 : '0;
        unique case (state_q)
            IDLE: begin
                if (step_up) begin
                    tgt_d   = perf_q + 2'd1;
                    req_d   = perf_q + 2'd1;
                    vld_d   = 1'b1;
                    tmo_d   = '0;
                    state_d = V_UP;
                end else if (step_dn) begin
                    tgt_d   = perf_q - 2'd1;
                    state_d = F_SWITCH;
                end
            end
            V_UP, V_DOWN: begin
                if (vld_q && volt_ack) begin
                    vld_d   = 1'b0;
                    volt_d  = req_q;
                    state_d = (state_q == V_UP) ? F_SWITCH : IDLE;
                end else if (vld_q && tmo_q == TMO_LAST) begin
                    vld_d   = 1'b0;
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            F_SWITCH: begin
                if (aligned) begin
                    perf_d = tgt_q;
                    if (tgt_q > perf_q) begin
                        state_d = IDLE;
                    end else begin
                        req_d   = tgt_q;
                        vld_d   = 1'b1;
                        tmo_d   = '0;
                        state_d = V_DOWN;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        case (perf_q)
            2'd2:    clk_d = clk_div2;
            2'd1:    clk_d = clk_div4;
            default: clk_d = clk_div8;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            win_q   <= '0;
            busy_q  <= '0;
            tgt_q   <= '0;
            perf_q  <= '0;
            volt_q  <= '0;
            req_q   <= '0;
            vld_q   <= 1'b0;
            tmo_q   <= '0;
            err_q   <= 1'b0;
            clk_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            busy_q  <= busy_d;
            tgt_q   <= tgt_d;
            perf_q  <= perf_d;
            volt_q  <= volt_d;
            req_q   <= req_d;
            vld_q   <= vld_d;
            tmo_q   <= tmo_d;
            err_q   <= err_d;
            clk_q   <= clk_d;
        end
    end

    assign clk_out        = clk_q;
    assign perf_level     = perf_q;
    assign volt_level     = volt_q;
    assign volt_req       = req_q;
    assign volt_req_valid = vld_q;
    assign switching      = state_q != IDLE;
    assign err_timeout    = err_q;

endmodule

// File: tb/tb_dvfs_controller.sv
// Bench for dvfs_controller: directed vector table plus reset/force/clock sequences.
// Drives a 3-bit divider model for clk_div2/4/8 and checks levels, handshake and clk_out.
module tb_dvfs_controller;

    logic       clk_in = 1'b0;
    logic       rst = 1'b1;
    logic       busy = 1'b0;
    logic       force_en = 1'b0;
    logic [1:0] force_level = 2'd0;
    logic       volt_ack = 1'b0;
    logic       clk_out;
    logic [1:0] perf_level;
    logic [1:0] volt_level;
    logic [1:0] volt_req;
    logic       volt_req_valid;
    logic       switching;
    logic       err_timeout;
    logic [2:0] dc;

    int n_vec = 0;
    int n_bad = 0;
    int ord_bad = 0;
    int min_w = 1000000;
    int last_t = 0;
    bit lv = 1'b0;

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in or posedge rst) begin
        if (rst) dc <= 3'd0;
        else     dc <= dc + 3'd1;
    end

    dvfs_controller dut (
        .clk_in(clk_in), .rst(rst),
        .clk_div2(dc[0]), .clk_div4(dc[1]), .clk_div8(dc[2]),
        .busy(busy), .force_en(force_en), .force_level(force_level),
        .clk_out(clk_out), .perf_level(perf_level), .volt_level(volt_level),
        .volt_req(volt_req), .volt_req_valid(volt_req_valid), .volt_ack(volt_ack),
        .switching(switching), .err_timeout(err_timeout)
    );

    always @(negedge clk_in) begin
        if (!rst && volt_level < perf_level) ord_bad++;
    end

    always @(clk_out) begin
        if (rst) begin
            lv = 1'b0;
        end else begin
            if (lv && (int'($time) - last_t) < min_w) min_w = int'($time) - last_t;
            last_t = int'($time);
            lv = 1'b1;
        end
    end

    typedef struct {
        logic       busy;
        logic       fen;
        logic [1:0] flev;
        logic       ack;
        int         ncyc;
        logic [1:0] perf;
        logic [1:0] volt;
        logic [1:0] req;
        logic       vld;
        logic       sw;
        logic       err;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic b, logic f, logic [1:0] fl, logic a, int n,
                                logic [1:0] p, logic [1:0] v, logic [1:0] r,
                                logic vl, logic s, logic e);
        vec_t t;
        t.busy = b; t.fen = f; t.flev = fl; t.ack = a; t.ncyc = n;
        t.perf = p; t.volt = v; t.req = r; t.vld = vl; t.sw = s; t.err = e;
        return t;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, got, exp);
        end
    endtask

    task automatic run_until(input logic [1:0] lvl, input string nm);
        bit done;
        done = 1'b0;
        for (int k = 0; k < 400 && !done; k++) begin
            volt_ack = volt_req_valid;
            tick(1);
            done = (perf_level == lvl) && !switching;
        end
        volt_ack = 1'b0;
        n_vec++;
        if (!done) begin
            n_bad++;
            $display("FAIL %s: got perf=%0d sw=%0d want perf=%0d idle",
                     nm, perf_level, switching, lvl);
        end
    endtask

    task automatic check_period(input int exp, input string nm);
        int   last;
        int   rises;
        int   bad;
        logic prev;
        last = -1; rises = 0; bad = 0;
        prev = clk_out;
        for (int k = 0; k < 48; k++) begin
            tick(1);
            if (clk_out && !prev) begin
                if (last >= 0 && (k - last) != exp) bad++;
                last = k;
                rises++;
            end
            prev = clk_out;
        end
        n_vec++;
        if (bad != 0 || rises < 3) begin
            n_bad++;
            $display("FAIL %s: got %0d rises, %0d wrong gaps, want period %0d",
                     nm, rises, bad, exp);
        end
    endtask

    initial begin
        logic [2:0] pv;
        vec_t       t;

        tbl.push_back(mk(1, 0, 0, 0, 255,  0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 1,    0, 0, 1, 1, 1, 0));
        tbl.push_back(mk(1, 0, 0, 0, 4,    0, 0, 1, 1, 1, 0));
        tbl.push_back(mk(1, 0, 0, 1, 1,    0, 1, 1, 0, 1, 0));
        tbl.push_back(mk(1, 0, 0, 0, 3,    0, 1, 1, 0, 1, 0));
        tbl.push_back(mk(1, 0, 0, 0, 1,    1, 1, 1, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 246,  1, 1, 1, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 1,    1, 1, 2, 1, 1, 0));
        tbl.push_back(mk(1, 0, 0, 1, 1,    1, 2, 2, 0, 1, 0));
        tbl.push_back(mk(1, 0, 0, 0, 7,    1, 2, 2, 0, 1, 0));
        tbl.push_back(mk(1, 0, 0, 0, 1,    2, 2, 2, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 247,  2, 2, 2, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 1,    2, 2, 2, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 255,  2, 2, 2, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1,    1, 2, 1, 1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 3,    1, 2, 1, 1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 1, 1,    1, 1, 1, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 251,  1, 1, 2, 1, 1, 0));
        tbl.push_back(mk(1, 0, 0, 0, 1023, 1, 1, 2, 1, 1, 0));
        tbl.push_back(mk(1, 0, 0, 0, 1,    1, 1, 2, 0, 0, 1));
        tbl.push_back(mk(1, 0, 0, 0, 1,    1, 1, 2, 0, 0, 0));

        tick(3);
        chk("reset_state",
            {clk_out, perf_level, volt_level, volt_req, volt_req_valid, switching, err_timeout},
            32'd0);
        rst = 1'b0;

        foreach (tbl[i]) begin
            t = tbl[i];
            busy = t.busy;
            force_en = t.fen;
            force_level = t.flev;
            volt_ack = t.ack;
            tick(1);
            volt_ack = 1'b0;
            if (t.ncyc > 1) tick(t.ncyc - 1);
            n_vec++;
            if (perf_level !== t.perf || volt_level !== t.volt || volt_req !== t.req ||
                volt_req_valid !== t.vld || switching !== t.sw || err_timeout !== t.err) begin
                n_bad++;
                $display("FAIL vec%0d: got perf=%0d volt=%0d req=%0d vld=%0d sw=%0d err=%0d want perf=%0d volt=%0d req=%0d vld=%0d sw=%0d err=%0d",
                         i, perf_level, volt_level, volt_req, volt_req_valid, switching,
                         err_timeout, t.perf, t.volt, t.req, t.vld, t.sw, t.err);
            end
        end

        #3 rst = 1'b1;
        #1;
        chk("async_reset",
            {clk_out, perf_level, volt_level, volt_req, volt_req_valid, switching, err_timeout},
            32'd0);
        busy = 1'b0;
        @(posedge clk_in);
        #1 rst = 1'b0;
        for (int k = 0; k < 16; k++) begin
            tick(1);
            pv = dc - 3'd1;
            chk("div8_follow", {31'd0, clk_out}, {31'd0, pv[2]});
        end

        force_en = 1'b1;
        force_level = 2'd3;
        run_until(2'd2, "force_to_2");
        check_period(2, "period_lvl2");
        force_level = 2'd0;
        run_until(2'd0, "force_to_0");
        check_period(8, "period_lvl0");
        force_level = 2'd1;
        run_until(2'd1, "force_to_1");
        check_period(4, "period_lvl1");
        chk("min_pulse_ok", {31'd0, min_w >= 10}, 32'd1);

        force_level = 2'd2;
        begin
            bit seen;
            seen = 1'b0;
            for (int k = 0; k < 20 && !seen; k++) begin
                tick(1);
                seen = volt_req_valid;
            end
            chk("vup_req_seen", {31'd0, seen}, 32'd1);
        end
        #3 rst = 1'b1;
        #1;
        chk("reset_in_vup", {26'd0, volt_req_valid, perf_level, volt_level, switching}, 32'd0);
        force_en = 1'b0;
        @(posedge clk_in);
        #1 rst = 1'b0;
        tick(2);
        volt_ack = 1'b1;
        tick(1);
        volt_ack = 1'b0;
        tick(2);
        chk("late_ack_ignored", {26'd0, volt_req_valid, perf_level, volt_level, switching}, 32'd0);

        chk("volt_ge_perf", ord_bad, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
